ov7670_sensor_emu: RTL
======================

// Module: ov7670_sensor_emu
// PURPOSE
//  Emulates the OV7670 parallel video output, i.e. the transmit end of the camera capture interface.
//  Drives PCLK/HREF/VSYNC/D[7:0] with deterministic RGB565 frames so the capture path and pixel statistics run on the bench and on the board.
//  Sits in front of the capture logic in place of the sensor pins.
// PARAMETERS
//  PCLK_DIV  4    system clocks per PCLK period; even, >=2
//  H_ACTIVE  640  pixels per active line (2 bytes/pixel)
//  H_BLANK   288  PCLK ticks of HREF-low per line
//  V_SYNC    3    lines with VSYNC high
//  V_BACK    17   blank lines after VSYNC
//  V_ACTIVE  480  active lines
//  V_FRONT   10   blank lines after the active lines
// PORTS
//  CLK100MHZ    in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  enable       in   1   level; frames are generated while high
//  pattern_sel  in   2   pattern select (used only with the optional feature)
//  solid_color  in   16  RGB565 fill colour (used only with the optional feature)
//  emu_plk      out  1   pixel clock
//  emu_hs       out  1   HREF, active high
//  emu_vs       out  1   VSYNC, active high
//  emu_data     out  8   pixel byte
//  busy         out  1   high while a frame is in progress
//  frame_start  out  1   one CLK100MHZ pulse as each frame enters V_SYNC
//  frame_count  out  16  frames completed; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; all counters 0.
//  - Tick and PCLK
//    - Tick = PCLK_DIV system clocks.
//    - emu_plk is low for the first PCLK_DIV/2 clocks of a tick, high for the rest.
//    - emu_hs, emu_vs, emu_data are registered and change only on the clock where emu_plk falls.
//    - Consumer samples on the PCLK rising edge.
//  - PCLK runs continuously out of reset, including in IDLE.
//  - Line: 2*H_ACTIVE + H_BLANK ticks.
//    - In ACTIVE lines emu_hs is high for the first 2*H_ACTIVE ticks; otherwise emu_hs=0.
//    - emu_data=0 whenever emu_hs=0.
//  - Frame: V_SYNC+V_BACK+V_ACTIVE+V_FRONT lines.
//  - FSM (transitions on tick boundaries only):
//    - IDLE->VSYNC when enable=1 at a tick start.
//    - VSYNC->VBACK->ACTIVE->VFRONT, each after its line count.
//    - VFRONT->VSYNC if enable=1, else ->IDLE.
//    - emu_vs=1 only in VSYNC.
//    - busy=0 only in IDLE.
//  - enable dropped mid-frame: the frame completes; no truncation.
//  - frame_count increments on the last tick of VFRONT.
//  - Counters: h 12 bit, v 10 bit, x = pixel index within the line, y = active-line index.
//  - Byte order: high RGB565 byte first, then low byte.
//  - Default pattern (ramp): byte0 = x[7:0], byte1 = y[7:0].
//  - Reset mid-frame: outputs return to 0 immediately; the next frame restarts from VSYNC.
// CONFIGURATION
//  - Macro SENSOR_EMU_PATTERN_EN defined: pattern_sel selects
//    - 0 = ramp (as above)
//    - 1 = 8 vertical colour bars, each H_ACTIVE/8 wide
//      - RGB565 order: FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000
//    - 2 = solid_color, sampled at frame_start and held for that frame
//    - 3 = 32x32 checker, FFFF when x[5]^y[5] else 0000
//    - pattern_sel is sampled at frame_start only.
//  - Macro undefined: ramp only; pattern_sel and solid_color are ignored.
// STRUCTURE
//  - Package sensor_emu_pkg:
//    - state enum {IDLE,VSYNC,VBACK,ACTIVE,VFRONT}
//    - colour-bar RGB565 constant table
//    - pattern code localparams
//  - Sub-module ov7670_pattern_gen: (x, y, byte_phase, pattern, colour) -> byte, registered one tick ahead.
// TESTING
//  - Reset then enable=1, PCLK_DIV=4:
//    - emu_plk period is 40 ns, 50% duty.
//    - frame_start occurs within 1 tick.
//    - emu_vs is high for exactly 3*(1568) ticks.
//  - Small parameters (H_ACTIVE=4, H_BLANK=2, V_*=1,1,3,1), ramp pattern:
//    - each active line carries bytes 00,y,01,y,02,y,03,y, with y=0..2.
//    - HREF high for 8 ticks, data 0 during blanking.
//  - Drop enable during ACTIVE of frame 1:
//    - the frame finishes; frame_count=1; busy falls after VFRONT.
//    - no second frame_start.
//  - Hold enable with frame_count preloaded to 0xFFFF via force: next completed frame gives 0x0000.
//  - SENSOR_EMU_PATTERN_EN with pattern_sel=1, H_ACTIVE=16:
//    - pixels 0-1 = FF,FF; pixels 2-3 = FF,E0; pixels 14-15 = 00,00.
//    - pattern_sel changed mid-frame takes effect next frame only.
//  - Assert rst_n low mid-line:
//    - outputs are 0 asynchronously.
//    - after release with enable=1, a full V_SYNC is generated before any HREF.

Source files
------------

// File: rtl/sensor_emu_pkg.sv
// Shared types and constants for the OV7670 sensor emulator: FSM states, pattern codes, colour-bar table.
package sensor_emu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_e;

    localparam logic [1:0] PAT_RAMP    = 2'd0;
    localparam logic [1:0] PAT_BARS    = 2'd1;
    localparam logic [1:0] PAT_SOLID   = 2'd2;
    localparam logic [1:0] PAT_CHECKER = 2'd3;

    // Left-to-right bar colours; index 0 is the leftmost bar.
    localparam logic [0:7][15:0] BAR_RGB565 = {
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    // The sensor sends the high RGB565 byte first.
    function automatic logic [7:0] rgb565_byte(input logic [15:0] px, input logic phase);
        return phase ? px[7:0] : px[15:8];
    endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Pixel-byte generator: maps the next tick's (x, y, byte phase) to the byte driven on D[7:0].
module ov7670_pattern_gen
    import sensor_emu_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic        CLK100MHZ,
    input  logic        rst_n,
    input  logic        load,
    input  logic        active,
    input  logic [10:0] x,
    input  logic [7:0]  y,
    input  logic        byte_phase,
    input  logic [1:0]  pattern,
    input  logic [15:0] colour,
    output logic [7:0]  data
);

    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [2:0]  bar_idx;
    logic [15:0] pixel;
    logic [7:0]  data_d, data_q;

    assign bar_idx = 3'(x / 11'(BAR_W));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pixel  = {x[7:0], y};
        data_d = data_q;
        case (pattern)
            PAT_BARS:    pixel = BAR_RGB565[bar_idx];
            PAT_SOLID:   pixel = colour;
            PAT_CHECKER: pixel = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
            default:     pixel = {x[7:0], y};
        endcase
        if (load) begin
            data_d = active ? rgb565_byte(pixel, byte_phase) : 8'h00;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 8'h00;
        end else begin
            // NOTE: state flops use non-blocking assignment so all flops update from pre-edge values.
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/ov7670_sensor_emu.sv
// OV7670 parallel-output emulator: PCLK, HREF, VSYNC and D[7:0] framing around ov7670_pattern_gen.
// Define SENSOR_EMU_PATTERN_EN to enable pattern_sel/solid_color; otherwise only the ramp is produced.
module ov7670_sensor_emu
    import sensor_emu_pkg::*;
#(
    parameter int PCLK_DIV = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 288,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        CLK100MHZ,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        emu_plk,
    output logic        emu_hs,
    output logic        emu_vs,
    output logic [7:0]  emu_data,
    output logic        busy,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int DIV_W      = $clog2(PCLK_DIV);
    localparam int HALF       = PCLK_DIV / 2;
    localparam int HREF_TICKS = 2 * H_ACTIVE;
    localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;

    function automatic int state_lines(input state_e s);
        case (s)
            VSYNC:   return V_SYNC;
            VBACK:   return V_BACK;
            ACTIVE:  return V_ACTIVE;
            VFRONT:  return V_FRONT;
            default: return 1;
        endcase
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic             plk_q, plk_d;
    state_e           state_q, state_d;
    logic [11:0]      h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             busy_q, busy_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             tick_end, line_end;
    logic [1:0]       pattern;
    logic [15:0]      colour;

    assign tick_end = (div_q == DIV_W'(PCLK_DIV - 1));
    assign line_end = (h_q == 12'(LINE_TICKS - 1));

    // Position, sync and HREF all advance on the clock where PCLK falls.
    always_comb begin
        div_d         = tick_end ? '0 : div_q + 1'b1;
        plk_d         = (div_d >= DIV_W'(HALF));
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        busy_d        = busy_q;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;

        if (tick_end) begin
            if (state_q == IDLE) begin
                if (enable) begin
                    state_d       = VSYNC;
                    h_d           = '0;
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end
            end else begin
                h_d = line_end ? '0 : h_q + 1'b1;
                if (line_end) begin
                    if (v_q == 10'(state_lines(state_q) - 1)) begin
                        v_d = '0;
                        case (state_q)
                            VSYNC:  state_d = VBACK;
                            VBACK:  state_d = ACTIVE;
                            ACTIVE: state_d = VFRONT;
                            VFRONT: begin
                                frame_count_d = frame_count_q + 1'b1;
                                if (enable) begin
                                    state_d       = VSYNC;
                                    frame_start_d = 1'b1;
                                end else begin
                                    state_d = IDLE;
                                end
                            end
                            default: state_d = IDLE;
                        endcase
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end
            end
            hs_d   = (state_d == ACTIVE) && (h_d < 12'(HREF_TICKS));
            vs_d   = (state_d == VSYNC);
            busy_d = (state_d != IDLE);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            plk_q         <= 1'b0;
            state_q       <= IDLE;
            h_q           <= '0;
            v_q           <= '0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            div_q         <= div_d;
            plk_q         <= plk_d;
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef SENSOR_EMU_PATTERN_EN
    // Pattern and fill colour are frozen per frame so mid-frame changes never tear the image.
    logic [1:0]  pattern_q, pattern_d;
    logic [15:0] colour_q, colour_d;

    always_comb begin
        pattern_d = pattern_q;
        colour_d  = colour_q;
        if (frame_start_d) begin
            pattern_d = pattern_sel;
            colour_d  = solid_color;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= PAT_RAMP;
            colour_q  <= '0;
        end else begin
            pattern_q <= pattern_d;
            colour_q  <= colour_d;
        end
    end

    assign pattern = pattern_q;
    assign colour  = colour_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{pattern_sel, solid_color};
    assign pattern    = PAT_RAMP;
    assign colour     = '0;
`endif

    ov7670_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .CLK100MHZ  (CLK100MHZ),
        .rst_n      (rst_n),
        .load       (tick_end),
        .active     (hs_d),
        .x          (h_d[11:1]),
        .y          (v_d[7:0]),
        .byte_phase (h_d[0]),
        .pattern    (pattern),
        .colour     (colour),
        .data       (emu_data)
    );

    assign emu_plk     = plk_q;
    assign emu_hs      = hs_q;
    assign emu_vs      = vs_q;
    assign busy        = busy_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
